// File: rtl/segway_math_pipe_if.sv
// Sample/command bundle between the balance controller, the drive-math pipe and the motor stage.
// The master drives samples and receives speed commands; the slave is the datapath.
interface segway_math_pipe_if #(
    parameter int W    = 12,
    parameter int SS_W = 8
);
    logic                vld_in;
    logic signed [W-1:0] PID_cntrl;
    logic [SS_W-1:0]     ss_tmr;
    logic [11:0]         steer_pot;
    logic                en_steer;
    logic                pwr_up;
    logic signed [W-1:0] lft_spd;
    logic signed [W-1:0] rght_spd;
    logic                spd_vld;
    logic                too_fast;

    modport master (
        output vld_in, PID_cntrl, ss_tmr, steer_pot, en_steer, pwr_up,
        input  lft_spd, rght_spd, spd_vld, too_fast
    );

    modport slave (
        input  vld_in, PID_cntrl, ss_tmr, steer_pot, en_steer, pwr_up,
        output lft_spd, rght_spd, spd_vld, too_fast
    );
endinterface

// File: rtl/segway_math_pipe.sv
// Three-stage drive math: soft-start scaling and steering, deadzone shaping,
// then saturation, per-sample slew limiting and persistent over-speed detection.
module segway_math_pipe #(
    parameter int W               = 12,
    parameter int SS_W            = 8,
    parameter int MIN_DUTY        = 'h3C0,
    parameter int LOW_TORQUE_BAND = 'h3C,
    parameter int GAIN_MULT       = 16,
    parameter int SLEW_STEP       = 'h20,
    parameter int FAST_THRESH     = 1792,
    parameter int FAST_CNT        = 4
) (
    input logic              clk,
    input logic              rst,
    segway_math_pipe_if.slave bus
);
    localparam int TW = W + 1;
    localparam int PW = W + SS_W + 1;
    localparam int CW = $clog2(FAST_CNT + 1);

    localparam logic signed [TW-1:0] BAND_T  = TW'(LOW_TORQUE_BAND);
    localparam logic signed [TW-1:0] NBAND_T = -BAND_T;
    localparam logic signed [TW-1:0] DUTY_T  = TW'(MIN_DUTY);
    localparam logic signed [TW-1:0] GAIN_T  = TW'(GAIN_MULT);
    localparam logic signed [TW-1:0] SLEW_T  = TW'(SLEW_STEP);
    localparam logic signed [TW-1:0] MAX_T   = TW'((2 ** (W - 1)) - 1);
    localparam logic signed [TW-1:0] MIN_T   = -TW'(2 ** (W - 1));
    localparam logic signed [W-1:0]  THR_T   = W'(FAST_THRESH);
    localparam logic [CW-1:0]        CNT_MAX = CW'(FAST_CNT);

    logic                 s1_vld_d, s1_vld_q;
    logic signed [W-1:0]  pid_ss_d, pid_ss_q;
    logic signed [W-1:0]  steer_d, steer_q;
    logic                 en_steer1_d, en_steer1_q;
    logic                 pwr_up1_d, pwr_up1_q;
    logic                 s2_vld_d, s2_vld_q;
    logic signed [TW-1:0] lft_tq_d, lft_tq_q;
    logic signed [TW-1:0] rght_tq_d, rght_tq_q;
    logic                 pwr_up2_d, pwr_up2_q;
    logic signed [W-1:0]  lft_spd_d, lft_spd_q;
    logic signed [W-1:0]  rght_spd_d, rght_spd_q;
    logic                 spd_vld_d, spd_vld_q;
    logic [CW-1:0]        cnt_d, cnt_q;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_shr;
    logic [11:0]          pot_sat;
    logic signed [11:0]   steer_s;
    logic signed [11:0]   steer12;
    logic signed [TW-1:0] lft_raw, rght_raw;

    // Small-torque region is boosted by the gain; beyond it a fixed offset clears the motor deadzone.
    function automatic logic signed [TW-1:0] shape(input logic signed [TW-1:0] t);
        if (t > BAND_T)       return t + DUTY_T;
        else if (t < NBAND_T) return t - DUTY_T;
        else                  return t * GAIN_T;
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [TW-1:0] t);
        if (t > MAX_T)      return MAX_T[W-1:0];
        else if (t < MIN_T) return MIN_T[W-1:0];
        else                return t[W-1:0];
    endfunction

    // Difference taken one bit wider so a full-scale swing cannot wrap.
    function automatic logic signed [W-1:0] slew(input logic signed [W-1:0] tgt,
                                                 input logic signed [W-1:0] cur);
        logic signed [TW-1:0] diff;
        logic signed [TW-1:0] step;
        diff = TW'(tgt) - TW'(cur);
        step = TW'(cur);
        if (diff > SLEW_T)       step = step + SLEW_T;
        else if (diff < -SLEW_T) step = step - SLEW_T;
        else                     step = TW'(tgt);
        return step[W-1:0];
    endfunction

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        s1_vld_d    = bus.vld_in;
        pid_ss_d    = pid_ss_q;
        steer_d     = steer_q;
        en_steer1_d = en_steer1_q;
        pwr_up1_d   = pwr_up1_q;

        prod     = $signed(bus.PID_cntrl) * $signed({1'b0, bus.ss_tmr});
        prod_shr = prod >>> SS_W;
        pot_sat  = bus.steer_pot;
        if (bus.steer_pot < 12'h200)      pot_sat = 12'h200;
        else if (bus.steer_pot > 12'hE00) pot_sat = 12'hE00;
        steer_s = $signed(pot_sat - 12'h7FF);
        steer12 = (steer_s >>> 4) + (steer_s >>> 3);

        if (bus.vld_in) begin
            pid_ss_d    = prod_shr[W-1:0];
            steer_d     = W'(steer12);
            en_steer1_d = bus.en_steer;
            pwr_up1_d   = bus.pwr_up;
        end

        s2_vld_d  = s1_vld_q;
        lft_tq_d  = lft_tq_q;
        rght_tq_d = rght_tq_q;
        pwr_up2_d = pwr_up2_q;
        lft_raw   = TW'(pid_ss_q);
        rght_raw  = TW'(pid_ss_q);
        if (en_steer1_q) begin
            lft_raw  = TW'(pid_ss_q) + TW'(steer_q);
            rght_raw = TW'(pid_ss_q) - TW'(steer_q);
        end
        if (s1_vld_q) begin
            lft_tq_d  = shape(lft_raw);
            rght_tq_d = shape(rght_raw);
            pwr_up2_d = pwr_up1_q;
        end

        spd_vld_d  = s2_vld_q;
        lft_spd_d  = lft_spd_q;
        rght_spd_d = rght_spd_q;
        cnt_d      = cnt_q;
        if (s2_vld_q) begin
            if (!pwr_up2_q) begin
                lft_spd_d  = '0;
                rght_spd_d = '0;
                cnt_d      = '0;
            end else begin
                lft_spd_d  = slew(sat(lft_tq_q), lft_spd_q);
                rght_spd_d = slew(sat(rght_tq_q), rght_spd_q);
                if (lft_spd_d > THR_T || rght_spd_d > THR_T)
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                else
                    cnt_d = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            pid_ss_q    <= '0;
            steer_q     <= '0;
            en_steer1_q <= 1'b0;
            pwr_up1_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            lft_tq_q    <= '0;
            rght_tq_q   <= '0;
            pwr_up2_q   <= 1'b0;
            lft_spd_q   <= '0;
            rght_spd_q  <= '0;
            spd_vld_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            pid_ss_q    <= pid_ss_d;
            steer_q     <= steer_d;
            en_steer1_q <= en_steer1_d;
            pwr_up1_q   <= pwr_up1_d;
            s2_vld_q    <= s2_vld_d;
            lft_tq_q    <= lft_tq_d;
            rght_tq_q   <= rght_tq_d;
            pwr_up2_q   <= pwr_up2_d;
            lft_spd_q   <= lft_spd_d;
            rght_spd_q  <= rght_spd_d;
            spd_vld_q   <= spd_vld_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.lft_spd  = lft_spd_q;
    assign bus.rght_spd = rght_spd_q;
    assign bus.spd_vld  = spd_vld_q;
    assign bus.too_fast = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_segway_math_pipe.sv
// Directed bench: one pipe with default slew and one with a wide slew step,
// driven from shared stimulus and checked against hand-computed vectors.
module tb_segway_math_pipe;
    typedef struct {
        logic [11:0] pid;
        logic [7:0]  ss;
        logic [11:0] pot;
        logic        en;
        logic        pw;
        logic [11:0] e_l;
        logic [11:0] e_r;
        logic        e_tf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [11:0] pid;
    logic [7:0]  ss;
    logic [11:0] pot;
    logic        ens;
    logic        pwr;
    logic        dsel;
    logic [11:0] o_l, o_r;
    logic        o_v, o_tf;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t stim[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    segway_math_pipe_if #(.W(12), .SS_W(8)) if_a ();
    segway_math_pipe_if #(.W(12), .SS_W(8)) if_b ();

    assign if_a.vld_in    = vld;
    assign if_a.PID_cntrl = pid;
    assign if_a.ss_tmr    = ss;
    assign if_a.steer_pot = pot;
    assign if_a.en_steer  = ens;
    assign if_a.pwr_up    = pwr;
    assign if_b.vld_in    = vld;
    assign if_b.PID_cntrl = pid;
    assign if_b.ss_tmr    = ss;
    assign if_b.steer_pot = pot;
    assign if_b.en_steer  = ens;
    assign if_b.pwr_up    = pwr;

    segway_math_pipe u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    segway_math_pipe #(.SLEW_STEP('h800)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    assign o_l  = dsel ? if_b.lft_spd  : if_a.lft_spd;
    assign o_r  = dsel ? if_b.rght_spd : if_a.rght_spd;
    assign o_v  = dsel ? if_b.spd_vld  : if_a.spd_vld;
    assign o_tf = dsel ? if_b.too_fast : if_a.too_fast;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [11:0] p, input logic [7:0] s, input logic [11:0] sp,
                                input logic e, input logic w, input logic [11:0] l,
                                input logic [11:0] r, input logic tf);
        vec_t v;
        v = '{p, s, sp, e, w, l, r, tf};
        return v;
    endfunction

    // Streams the queued samples back to back; sample c surfaces three edges after it is driven.
    task automatic run_stream(input logic sel, input string tag);
        int n;
        n    = stim.size();
        dsel = sel;
        for (int c = 0; c <= n + 3; c++) begin
            if (c == 1 || c == 2)
                check($sformatf("%s early vld c%0d", tag, c), {11'd0, o_v}, 12'd0);
            if (c >= 3 && c < n + 3) begin
                check($sformatf("%s[%0d] vld", tag, c - 3), {11'd0, o_v}, 12'd1);
                check($sformatf("%s[%0d] lft", tag, c - 3), o_l, stim[c-3].e_l);
                check($sformatf("%s[%0d] rght", tag, c - 3), o_r, stim[c-3].e_r);
                check($sformatf("%s[%0d] too_fast", tag, c - 3), {11'd0, o_tf}, {11'd0, stim[c-3].e_tf});
            end
            if (c == n + 3)
                check($sformatf("%s vld end", tag), {11'd0, o_v}, 12'd0);
            if (c < n) begin
                vld = 1'b1;
                pid = stim[c].pid;
                ss  = stim[c].ss;
                pot = stim[c].pot;
                ens = stim[c].en;
                pwr = stim[c].pw;
            end else begin
                vld = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        vld  = 1'b0;
        pid  = '0;
        ss   = '0;
        pot  = 12'h800;
        ens  = 1'b0;
        pwr  = 1'b1;
        dsel = 1'b0;

        tbl[0]  = mk(12'h010, 8'hFF, 12'h800, 1'b0, 1'b1, 12'h0F0, 12'h0F0, 1'b0);
        tbl[1]  = mk(12'hFF0, 8'hFF, 12'h800, 1'b0, 1'b1, 12'hF00, 12'hF00, 1'b0);
        tbl[2]  = mk(12'h000, 8'hFF, 12'hFFF, 1'b1, 1'b1, 12'h4E0, 12'hB20, 1'b0);
        tbl[3]  = mk(12'h000, 8'hFF, 12'h000, 1'b1, 1'b1, 12'hB20, 12'h4E0, 1'b0);
        tbl[4]  = mk(12'h000, 8'hFF, 12'hFFF, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
        tbl[5]  = mk(12'h100, 8'hFF, 12'hFFF, 1'b1, 1'b1, 12'h5DF, 12'hDF0, 1'b0);
        tbl[6]  = mk(12'h000, 8'hFF, 12'h80F, 1'b1, 1'b1, 12'h030, 12'hFD0, 1'b0);
        tbl[7]  = mk(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 12'h7FF, 12'h7FF, 1'b0);
        tbl[8]  = mk(12'h800, 8'hFF, 12'h800, 1'b0, 1'b1, 12'h800, 12'h800, 1'b0);
        tbl[9]  = mk(12'h078, 8'h80, 12'h800, 1'b0, 1'b1, 12'h3C0, 12'h3C0, 1'b0);
        tbl[10] = mk(12'h07A, 8'h80, 12'h800, 1'b0, 1'b1, 12'h3FD, 12'h3FD, 1'b0);
        tbl[11] = mk(12'hF88, 8'h80, 12'h800, 1'b0, 1'b1, 12'hC40, 12'hC40, 1'b0);
        tbl[12] = mk(12'hF86, 8'h80, 12'h800, 1'b0, 1'b1, 12'hC03, 12'hC03, 1'b0);
        tbl[13] = mk(12'h7FF, 8'h00, 12'h800, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
        tbl[14] = mk(12'h100, 8'hFF, 12'hFFF, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0);
        tbl[15] = mk(12'h000, 8'hFF, 12'h300, 1'b1, 1'b1, 12'hB50, 12'h4B0, 1'b0);

        tick();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            dsel = s[0];
            #0;
            check($sformatf("reset%0d lft", s), o_l, 12'h000);
            check($sformatf("reset%0d rght", s), o_r, 12'h000);
            check($sformatf("reset%0d vld", s), {11'd0, o_v}, 12'd0);
            check($sformatf("reset%0d too_fast", s), {11'd0, o_tf}, 12'd0);
        end

        for (int i = 0; i < 16; i++) begin
            do_reset();
            stim.delete();
            stim.push_back(tbl[i]);
            run_stream(1'b1, $sformatf("vec%0d", i));
        end

        // Default slew: 0x20 per sample until the 0x4BF target is reached on sample 38.
        do_reset();
        stim.delete();
        for (int k = 1; k <= 40; k++)
            stim.push_back(mk(12'h100, 8'hFF, 12'h800, 1'b0, 1'b1,
                              (32 * k < 12'h4BF) ? 12'(32 * k) : 12'h4BF,
                              (32 * k < 12'h4BF) ? 12'(32 * k) : 12'h4BF, 1'b0));
        run_stream(1'b0, "slew");
        vld = 1'b0;
        repeat (3) tick();
        check("gap hold lft", o_l, 12'h4BF);
        check("gap hold vld", {11'd0, o_v}, 12'd0);
        stim.delete();
        stim.push_back(mk(12'h100, 8'hFF, 12'h800, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0));
        run_stream(1'b0, "pwr_off");

        do_reset();
        stim.delete();
        for (int k = 1; k <= 6; k++)
            stim.push_back(mk(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 12'h7FF, 12'h7FF, k >= 4));
        stim.push_back(mk(12'h000, 8'hFF, 12'h800, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0));
        run_stream(1'b1, "fast");

        stim.delete();
        for (int k = 1; k <= 3; k++)
            stim.push_back(mk(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 12'h7FF, 12'h7FF, 1'b0));
        run_stream(1'b1, "fast_pre_gap");
        stim.delete();
        stim.push_back(mk(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 12'h7FF, 12'h7FF, 1'b1));
        run_stream(1'b1, "fast_post_gap");
        stim.delete();
        stim.push_back(mk(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0));
        stim.push_back(mk(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 12'h7FF, 12'h7FF, 1'b0));
        run_stream(1'b1, "fast_pwr_clr");

        do_reset();
        stim.delete();
        for (int k = 1; k <= 5; k++)
            stim.push_back(mk(12'h344, 8'hFF, 12'h800, 1'b0, 1'b1, 12'h700, 12'h700, 1'b0));
        run_stream(1'b1, "thresh_eq");
        do_reset();
        stim.delete();
        for (int k = 1; k <= 5; k++)
            stim.push_back(mk(12'h345, 8'hFF, 12'h800, 1'b0, 1'b1, 12'h701, 12'h701, k >= 4));
        run_stream(1'b1, "thresh_gt");

        // Reset with two samples still in the pipe: nothing may emerge afterwards.
        dsel = 1'b1;
        pid  = 12'h7FF;
        ss   = 8'hFF;
        ens  = 1'b0;
        pwr  = 1'b1;
        vld  = 1'b1;
        tick();
        tick();
        vld = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_mid lft", o_l, 12'h000);
        check("rst_mid rght", o_r, 12'h000);
        check("rst_mid vld", {11'd0, o_v}, 12'd0);
        check("rst_mid too_fast", {11'd0, o_tf}, 12'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("rst_mid drain%0d vld", c), {11'd0, o_v}, 12'd0);
        end
        stim.delete();
        stim.push_back(tbl[0]);
        run_stream(1'b1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
